urna_session_ctrl: RTL and testbench
====================================

URNA_SESSION_CTRL -- requirements
Module: urna_session_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1000, meaning idle cycles allowed in a voter session; legal range 1..65535.
REQ-002 Clock  in  1  clock; all state changes on rising edge.
REQ-003 Reset  in  1  reset, synchronous, active-high.
REQ-004 Authorize  in  1  poll-worker pulse that opens one voter session.
REQ-005 KeyValid  in  1  one-cycle strobe qualifying KeyDigit.
REQ-006 KeyDigit  in  4  keypad digit, binary.
REQ-007 Confirm  in  1  voter confirm key.
REQ-008 Cancel  in  1  voter clear key.
REQ-009 Close  in  1  end-of-election request.
REQ-010 VoteValid  out  1  vote offer to the counting unit.
REQ-011 VoteCode  out  3  0=null, 1..4=candidate C1..C4.
REQ-012 VoteReady  in  1  counting unit accepts the vote.
REQ-013 ReadIdx  out  3  counter select: 0=Nulo, 1..4=C1..C4.
REQ-014 ReadData  in  8  combinational counter value for ReadIdx.
REQ-015 ResultValid  out  1  one-cycle strobe qualifying ResultIdx/ResultData.
REQ-016 ResultIdx  out  3  index of reported counter.
REQ-017 ResultData  out  8  reported counter value.
REQ-018 Status  out  1  one-cycle pulse: vote accepted.
REQ-019 Timeout  out  1  one-cycle pulse: session aborted, no vote.
REQ-020 Busy  out  1  high in COLLECT, REVIEW, COMMIT, READOUT.
REQ-021 Closed  out  1  high in CLOSED.

Function
REQ-022 States: IDLE, COLLECT, REVIEW, COMMIT, READOUT, CLOSED; all outputs registered.
REQ-023 IDLE: Authorize -> COLLECT, digit count 0, digit buffer cleared, timer loaded with TIMEOUT; Close (without Authorize) -> READOUT; Authorize and Close together -> Authorize wins.
REQ-024 COLLECT: KeyValid stores KeyDigit at position = count (first digit most significant), count+1; fourth digit -> REVIEW.
REQ-025 Digits 10..15 are stored; the resulting code decodes to null.
REQ-026 Confirm in COLLECT ignored (but reloads timer).
REQ-027 Cancel in COLLECT or REVIEW: buffer cleared, count 0, state COLLECT; same-cycle KeyValid or Confirm discarded.
REQ-028 REVIEW: KeyValid ignored (reloads timer); Confirm -> COMMIT with VoteCode latched from decode.
REQ-029 Decode: 3-4-9-4 -> 1, 3-4-8-5 -> 2, 3-4-7-2 -> 3, 3-5-0-4 -> 4, any other -> 0.
REQ-030 Timer: in COLLECT/REVIEW reloaded to TIMEOUT on any KeyValid, Confirm or Cancel, else decremented; decrement from 1 -> IDLE, Timeout pulse next cycle, no vote offered.
REQ-031 COMMIT: VoteValid=1, VoteCode stable until VoteReady sampled high; on that edge VoteValid->0, Status=1 for one cycle, state IDLE.
REQ-032 COMMIT has no timeout; Cancel, Confirm, KeyValid, Authorize, Close ignored.
REQ-033 Authorize outside IDLE ignored; Close outside IDLE ignored.
REQ-034 READOUT: ReadIdx = 0,1,2,3,4 on 5 consecutive cycles starting cycle after Close accepted.
REQ-035 ResultValid high the cycle after each ReadIdx value, ResultIdx = that index, ResultData = ReadData sampled then; 5 consecutive strobes.
REQ-036 After the fifth strobe's cycle state CLOSED; Closed=1; all inputs except Reset ignored until Reset.
REQ-037 ReadIdx = 0 outside READOUT; VoteCode = 0 outside COMMIT; ResultIdx/ResultData hold last value.

Reset
REQ-038 Reset sampled high -> next cycle: state IDLE, count 0, buffer 0, timer 0, VoteValid 0, VoteCode 0, ReadIdx 0, ResultValid 0, ResultIdx 0, ResultData 0, Status 0, Timeout 0, Busy 0, Closed 0.
REQ-039 Reset overrides every other input in any state, including mid-COMMIT (offer withdrawn, no Status) and mid-READOUT (sequence abandoned).

Verification
REQ-040 Authorize; keys 3,4,9,4; Confirm; VoteReady high 3 cycles later -> VoteValid=1 VoteCode=1 held 3 cycles, Status pulse one cycle after acceptance, state IDLE.
REQ-041 Authorize; keys 3,5,0; Cancel; keys 3,4,7,2; Confirm with VoteReady tied 1 -> VoteCode=3, exactly one Status pulse.
REQ-042 Authorize; keys 3,4,12,5; Confirm -> VoteCode=0 (null); also Cancel+Confirm same cycle in REVIEW -> state COLLECT, no vote.
REQ-043 TIMEOUT=8; Authorize; key 3 then no input -> Timeout pulse 8 cycles after key edge, VoteValid never high, Busy 0.
REQ-044 Close in IDLE with ReadData = 10*ReadIdx+1 -> ResultValid 5 consecutive cycles, (idx,data) = (0,1),(1,11),(2,21),(3,31),(4,41), then Closed=1; later Authorize ignored.
REQ-045 Reset asserted during COMMIT with VoteReady 0 -> next cycle VoteValid 0, Status 0, state IDLE; Authorize then accepted normally.

Source files
------------

// File: rtl/urna_session_ctrl_if.sv
// Bus between the voter session controller, the vote counting unit and the result readout path.
// The master side is the session controller; the slave side is the counting unit.
interface urna_session_ctrl_if;
   logic       VoteValid;
   logic [2:0] VoteCode;
   logic       VoteReady;
   logic [2:0] ReadIdx;
   logic [7:0] ReadData;
   logic       ResultValid;
   logic [2:0] ResultIdx;
   logic [7:0] ResultData;

   modport master (
      output VoteValid, VoteCode, ReadIdx, ResultValid, ResultIdx, ResultData,
      input  VoteReady, ReadData
   );

   modport slave (
      input  VoteValid, VoteCode, ReadIdx, ResultValid, ResultIdx, ResultData,
      output VoteReady, ReadData
   );
endinterface

// File: rtl/urna_session_ctrl.sv
// Voting booth session controller: collects a 4-digit candidate code, offers the vote to the
// counting unit, enforces an idle timeout, and streams the five counters out at election close.
module urna_session_ctrl #(
   parameter int TIMEOUT = 1000
) (
   input  logic                       Clock,
   input  logic                       Reset,
   input  logic                       Authorize,
   input  logic                       KeyValid,
   input  logic [3:0]                 KeyDigit,
   input  logic                       Confirm,
   input  logic                       Cancel,
   input  logic                       Close,
   urna_session_ctrl_if.master        bus,
   output logic                       Status,
   output logic                       Timeout,
   output logic                       Busy,
   output logic                       Closed
);

   typedef enum logic [2:0] {IDLE, COLLECT, REVIEW, COMMIT, READOUT, CLOSED} stateT;

   localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

   stateT       state, stateNext;
   logic [1:0]  count, countNext;
   logic [15:0] buffer, bufferNext;
   logic [15:0] timer, timerNext;
   logic [2:0]  rdCnt, rdCntNext;
   logic        voteValidNext;
   logic [2:0]  voteCodeNext;
   logic [2:0]  readIdxNext;
   logic        resultValidNext;
   logic [2:0]  resultIdxNext;
   logic [7:0]  resultDataNext;
   logic        statusNext, timeoutNext, busyNext, closedNext;

   // Only the four registered candidate codes map to a candidate; everything else is a null vote.
   function automatic logic [2:0] decodeVote(input logic [15:0] code);
      case (code)
         16'h3494: decodeVote = 3'd1;
         16'h3485: decodeVote = 3'd2;
         16'h3472: decodeVote = 3'd3;
         16'h3504: decodeVote = 3'd4;
         default:  decodeVote = 3'd0;
      endcase
   endfunction

   // Next-state and next-output logic; every output is registered from these values.
   always_comb begin
      stateNext       = state;
      countNext       = count;
      bufferNext      = buffer;
      timerNext       = timer;
      rdCntNext       = rdCnt;
      voteValidNext   = 1'b0;
      voteCodeNext    = 3'd0;
      readIdxNext     = 3'd0;
      resultValidNext = 1'b0;
      resultIdxNext   = bus.ResultIdx;
      resultDataNext  = bus.ResultData;
      statusNext      = 1'b0;
      timeoutNext     = 1'b0;

      case (state)
         IDLE: begin
            if (Authorize) begin
               stateNext  = COLLECT;
               countNext  = 2'd0;
               bufferNext = 16'd0;
               timerNext  = TimeoutVal;
            end else if (Close) begin
               stateNext = READOUT;
               rdCntNext = 3'd0;
            end
         end

         COLLECT, REVIEW: begin
            if (Cancel) begin
               stateNext  = COLLECT;
               countNext  = 2'd0;
               bufferNext = 16'd0;
               timerNext  = TimeoutVal;
            end else if (KeyValid || Confirm) begin
               timerNext = TimeoutVal;
               if (state == COLLECT && KeyValid) begin
                  case (count)
                     2'd0:    bufferNext[15:12] = KeyDigit;
                     2'd1:    bufferNext[11:8]  = KeyDigit;
                     2'd2:    bufferNext[7:4]   = KeyDigit;
                     default: bufferNext[3:0]   = KeyDigit;
                  endcase
                  countNext = count + 2'd1;
                  if (count == 2'd3)
                     stateNext = REVIEW;
               end else if (state == REVIEW && Confirm) begin
                  stateNext     = COMMIT;
                  voteValidNext = 1'b1;
                  voteCodeNext  = decodeVote(buffer);
               end
            end else begin
               timerNext = timer - 16'd1;
               if (timer == 16'd1) begin
                  stateNext   = IDLE;
                  timeoutNext = 1'b1;
               end
            end
         end

         COMMIT: begin
            if (bus.VoteReady) begin
               stateNext  = IDLE;
               statusNext = 1'b1;
            end else begin
               voteValidNext = 1'b1;
               voteCodeNext  = bus.VoteCode;
            end
         end

         // rdCnt tracks which counter ReadIdx is currently presenting; the extra sixth step
         // lets the last strobe complete before entering CLOSED.
         READOUT: begin
            if (rdCnt == 3'd5) begin
               stateNext = CLOSED;
            end else begin
               resultValidNext = 1'b1;
               resultIdxNext   = rdCnt;
               resultDataNext  = bus.ReadData;
               readIdxNext     = (rdCnt == 3'd4) ? 3'd0 : rdCnt + 3'd1;
               rdCntNext       = rdCnt + 3'd1;
            end
         end

         CLOSED: begin
            stateNext = CLOSED;
         end

         default: stateNext = IDLE;
      endcase

      busyNext   = (stateNext == COLLECT) || (stateNext == REVIEW) ||
                   (stateNext == COMMIT)  || (stateNext == READOUT);
      closedNext = (stateNext == CLOSED);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state           <= IDLE;
         count           <= 2'd0;
         buffer          <= 16'd0;
         timer           <= 16'd0;
         rdCnt           <= 3'd0;
         bus.VoteValid   <= 1'b0;
         bus.VoteCode    <= 3'd0;
         bus.ReadIdx     <= 3'd0;
         bus.ResultValid <= 1'b0;
         bus.ResultIdx   <= 3'd0;
         bus.ResultData  <= 8'd0;
         Status          <= 1'b0;
         Timeout         <= 1'b0;
         Busy            <= 1'b0;
         Closed          <= 1'b0;
      end else begin
         state           <= stateNext;
         count           <= countNext;
         buffer          <= bufferNext;
         timer           <= timerNext;
         rdCnt           <= rdCntNext;
         bus.VoteValid   <= voteValidNext;
         bus.VoteCode    <= voteCodeNext;
         bus.ReadIdx     <= readIdxNext;
         bus.ResultValid <= resultValidNext;
         bus.ResultIdx   <= resultIdxNext;
         bus.ResultData  <= resultDataNext;
         Status          <= statusNext;
         Timeout         <= timeoutNext;
         Busy            <= busyNext;
         Closed          <= closedNext;
      end
   end

endmodule

// File: tb/tb_urna_session_ctrl.sv
// Directed bench for urna_session_ctrl: voting sessions, cancel, null votes, timeout,
// reset during a vote offer and the end-of-election counter readout.
module tb_urna_session_ctrl;

   logic       Clock;
   logic       Reset;
   logic       Authorize;
   logic       KeyValid;
   logic [3:0] KeyDigit;
   logic       Confirm;
   logic       Cancel;
   logic       Close;
   logic       Status;
   logic       Timeout;
   logic       Busy;
   logic       Closed;

   int checks   = 0;
   int failures = 0;

   urna_session_ctrl_if tbBus ();

   urna_session_ctrl #(.TIMEOUT(8)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Authorize (Authorize),
      .KeyValid  (KeyValid),
      .KeyDigit  (KeyDigit),
      .Confirm   (Confirm),
      .Cancel    (Cancel),
      .Close     (Close),
      .bus       (tbBus.master),
      .Status    (Status),
      .Timeout   (Timeout),
      .Busy      (Busy),
      .Closed    (Closed)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Counter bank model: counter n holds 10*n+1.
   assign tbBus.ReadData = ({5'd0, tbBus.ReadIdx} * 8'd10) + 8'd1;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] digit);
      KeyValid = 1'b1;
      KeyDigit = digit;
      tick();
      KeyValid = 1'b0;
      KeyDigit = 4'd0;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic enterCode(input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [3:0] d3);
      Authorize = 1'b1;
      tick();
      Authorize = 1'b0;
      applyStimulus(d0);
      applyStimulus(d1);
      applyStimulus(d2);
      applyStimulus(d3);
   endtask

   initial begin
      Reset = 1'b1;
      Authorize = 1'b0;
      KeyValid = 1'b0;
      KeyDigit = 4'd0;
      Confirm = 1'b0;
      Cancel = 1'b0;
      Close = 1'b0;
      tbBus.VoteReady = 1'b0;
      tick();
      tick();
      Reset = 1'b0;

      $display("[TB] reset state");
      checkOutput("rst_votevalid", 16'(tbBus.VoteValid), 16'd0);
      checkOutput("rst_votecode", 16'(tbBus.VoteCode), 16'd0);
      checkOutput("rst_readidx", 16'(tbBus.ReadIdx), 16'd0);
      checkOutput("rst_resultvalid", 16'(tbBus.ResultValid), 16'd0);
      checkOutput("rst_resultdata", 16'(tbBus.ResultData), 16'd0);
      checkOutput("rst_status", 16'(Status), 16'd0);
      checkOutput("rst_timeout", 16'(Timeout), 16'd0);
      checkOutput("rst_busy", 16'(Busy), 16'd0);
      checkOutput("rst_closed", 16'(Closed), 16'd0);

      $display("[TB] vote C1 with delayed VoteReady");
      enterCode(4'd3, 4'd4, 4'd9, 4'd4);
      checkOutput("c1_review_busy", 16'(Busy), 16'd1);
      checkOutput("c1_review_novote", 16'(tbBus.VoteValid), 16'd0);
      Confirm = 1'b1;
      tick();
      Confirm = 1'b0;
      checkOutput("c1_offer0_valid", 16'(tbBus.VoteValid), 16'd1);
      checkOutput("c1_offer0_code", 16'(tbBus.VoteCode), 16'd1);
      tick();
      checkOutput("c1_offer1_valid", 16'(tbBus.VoteValid), 16'd1);
      tick();
      checkOutput("c1_offer2_valid", 16'(tbBus.VoteValid), 16'd1);
      checkOutput("c1_offer2_code", 16'(tbBus.VoteCode), 16'd1);
      checkOutput("c1_offer2_nostatus", 16'(Status), 16'd0);
      tbBus.VoteReady = 1'b1;
      tick();
      tbBus.VoteReady = 1'b0;
      checkOutput("c1_acc_valid", 16'(tbBus.VoteValid), 16'd0);
      checkOutput("c1_acc_code", 16'(tbBus.VoteCode), 16'd0);
      checkOutput("c1_acc_status", 16'(Status), 16'd1);
      checkOutput("c1_acc_busy", 16'(Busy), 16'd0);
      tick();
      checkOutput("c1_status_end", 16'(Status), 16'd0);

      $display("[TB] cancel then vote C3 with VoteReady tied high");
      tbBus.VoteReady = 1'b1;
      Authorize = 1'b1;
      tick();
      Authorize = 1'b0;
      applyStimulus(4'd3);
      applyStimulus(4'd5);
      applyStimulus(4'd0);
      Cancel = 1'b1;
      tick();
      Cancel = 1'b0;
      applyStimulus(4'd3);
      applyStimulus(4'd4);
      applyStimulus(4'd7);
      checkOutput("c3_three_keys_novote", 16'(tbBus.VoteValid), 16'd0);
      applyStimulus(4'd2);
      Confirm = 1'b1;
      tick();
      Confirm = 1'b0;
      checkOutput("c3_offer_valid", 16'(tbBus.VoteValid), 16'd1);
      checkOutput("c3_offer_code", 16'(tbBus.VoteCode), 16'd3);
      checkOutput("c3_offer_nostatus", 16'(Status), 16'd0);
      tick();
      checkOutput("c3_acc_valid", 16'(tbBus.VoteValid), 16'd0);
      checkOutput("c3_acc_status", 16'(Status), 16'd1);
      tick();
      checkOutput("c3_single_status", 16'(Status), 16'd0);
      tbBus.VoteReady = 1'b0;

      $display("[TB] digit above 9 gives a null vote");
      enterCode(4'd3, 4'd4, 4'd12, 4'd5);
      Confirm = 1'b1;
      tick();
      Confirm = 1'b0;
      checkOutput("null_offer_valid", 16'(tbBus.VoteValid), 16'd1);
      checkOutput("null_offer_code", 16'(tbBus.VoteCode), 16'd0);
      tbBus.VoteReady = 1'b1;
      tick();
      tbBus.VoteReady = 1'b0;
      checkOutput("null_acc_status", 16'(Status), 16'd1);

      $display("[TB] cancel and confirm together in review");
      enterCode(4'd3, 4'd4, 4'd9, 4'd4);
      Cancel = 1'b1;
      Confirm = 1'b1;
      tick();
      Cancel = 1'b0;
      Confirm = 1'b0;
      checkOutput("cc_novote", 16'(tbBus.VoteValid), 16'd0);
      checkOutput("cc_busy", 16'(Busy), 16'd1);
      Confirm = 1'b1;
      tick();
      Confirm = 1'b0;
      checkOutput("cc_collect_confirm_ignored", 16'(tbBus.VoteValid), 16'd0);
      applyStimulus(4'd3);
      applyStimulus(4'd5);
      applyStimulus(4'd0);
      applyStimulus(4'd4);
      Confirm = 1'b1;
      tick();
      Confirm = 1'b0;
      checkOutput("c4_offer_code", 16'(tbBus.VoteCode), 16'd4);
      tbBus.VoteReady = 1'b1;
      tick();
      tbBus.VoteReady = 1'b0;
      checkOutput("c4_acc_status", 16'(Status), 16'd1);

      $display("[TB] extra key in review is ignored, vote C2");
      enterCode(4'd3, 4'd4, 4'd8, 4'd5);
      applyStimulus(4'd9);
      Confirm = 1'b1;
      tick();
      Confirm = 1'b0;
      checkOutput("c2_offer_code", 16'(tbBus.VoteCode), 16'd2);
      tbBus.VoteReady = 1'b1;
      tick();
      tbBus.VoteReady = 1'b0;
      checkOutput("c2_acc_status", 16'(Status), 16'd1);

      $display("[TB] session timeout after one key");
      Authorize = 1'b1;
      tick();
      Authorize = 1'b0;
      applyStimulus(4'd3);
      for (int i = 0; i < 7; i++) tick();
      checkOutput("to_before_pulse", 16'(Timeout), 16'd0);
      checkOutput("to_before_busy", 16'(Busy), 16'd1);
      tick();
      checkOutput("to_pulse", 16'(Timeout), 16'd1);
      checkOutput("to_busy", 16'(Busy), 16'd0);
      checkOutput("to_novote", 16'(tbBus.VoteValid), 16'd0);
      tick();
      checkOutput("to_pulse_end", 16'(Timeout), 16'd0);

      $display("[TB] reset during commit");
      enterCode(4'd3, 4'd4, 4'd9, 4'd4);
      Confirm = 1'b1;
      tick();
      Confirm = 1'b0;
      checkOutput("rc_offer_valid", 16'(tbBus.VoteValid), 16'd1);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      checkOutput("rc_valid", 16'(tbBus.VoteValid), 16'd0);
      checkOutput("rc_code", 16'(tbBus.VoteCode), 16'd0);
      checkOutput("rc_status", 16'(Status), 16'd0);
      checkOutput("rc_busy", 16'(Busy), 16'd0);
      tick();
      checkOutput("rc_status_after", 16'(Status), 16'd0);

      $display("[TB] authorize beats close, then time out");
      Authorize = 1'b1;
      Close = 1'b1;
      tick();
      Authorize = 1'b0;
      Close = 1'b0;
      checkOutput("ac_busy", 16'(Busy), 16'd1);
      tick();
      checkOutput("ac_no_readout", 16'(tbBus.ResultValid), 16'd0);
      for (int i = 0; i < 7; i++) tick();
      checkOutput("ac_timeout", 16'(Timeout), 16'd1);

      $display("[TB] election close readout");
      tick();
      Close = 1'b1;
      tick();
      Close = 1'b0;
      checkOutput("ro_readidx0", 16'(tbBus.ReadIdx), 16'd0);
      checkOutput("ro_busy", 16'(Busy), 16'd1);
      checkOutput("ro_no_strobe_yet", 16'(tbBus.ResultValid), 16'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput($sformatf("ro_valid%0d", i), 16'(tbBus.ResultValid), 16'd1);
         checkOutput($sformatf("ro_idx%0d", i), 16'(tbBus.ResultIdx), 16'(i));
         checkOutput($sformatf("ro_data%0d", i), 16'(tbBus.ResultData), 16'(10 * i + 1));
         checkOutput($sformatf("ro_readidx%0d", i), 16'(tbBus.ReadIdx),
                     16'((i < 4) ? i + 1 : 0));
      end
      tick();
      checkOutput("ro_valid_end", 16'(tbBus.ResultValid), 16'd0);
      checkOutput("ro_closed", 16'(Closed), 16'd1);
      checkOutput("ro_busy_end", 16'(Busy), 16'd0);
      checkOutput("ro_idx_hold", 16'(tbBus.ResultIdx), 16'd4);
      checkOutput("ro_data_hold", 16'(tbBus.ResultData), 16'd41);
      Authorize = 1'b1;
      tick();
      Authorize = 1'b0;
      tick();
      checkOutput("closed_auth_busy", 16'(Busy), 16'd0);
      checkOutput("closed_auth_closed", 16'(Closed), 16'd1);

      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      checkOutput("final_rst_closed", 16'(Closed), 16'd0);
      checkOutput("final_rst_resultdata", 16'(tbBus.ResultData), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
